// File: rtl/key_eeprom_cmd_sched.sv
// Key-event command scheduler for an AT24C02 I2C controller: queues key pulses,
// applies local address/data edits and sequences EEPROM reads/writes with write gap.
module key_eeprom_cmd_sched #(
  parameter int FIFO_DEPTH    = 4,
  parameter int WR_GAP_CYCLES = 250_000
) (
  input  logic       sclk_i,
  input  logic       rst_i,
  input  logic [3:0] key_pulse_i,
  input  logic       i2c_busy_i,
  input  logic       i2c_done_i,
  input  logic       i2c_err_i,
  input  logic [7:0] i2c_rd_data_i,
  output logic       i2c_req_o,
  output logic       i2c_rw_o,
  output logic [7:0] i2c_addr_o,
  output logic [7:0] i2c_wr_data_o,
  output logic [7:0] cur_addr_o,
  output logic [7:0] cur_data_o,
  output logic       rd_valid_o,
  output logic [7:0] rd_data_o,
  output logic       err_flag_o,
  output logic [7:0] drop_cnt_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int GW = (WR_GAP_CYCLES > 1) ? $clog2(WR_GAP_CYCLES) : 1;

  // Command codes match the key_pulse bit index.
  localparam logic [1:0] CMD_WRITE    = 2'd0;
  localparam logic [1:0] CMD_READ     = 2'd1;
  localparam logic [1:0] CMD_ADDR_INC = 2'd2;
  localparam logic [1:0] CMD_DATA_INC = 2'd3;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  // ---------------------------------------------------------------------------
  // Key arbitration and drop accounting
  // ---------------------------------------------------------------------------
  logic [1:0]    key_cmd;
  logic [2:0]    key_cnt;
  logic [3:0]    drops;
  logic [8:0]    drop_sum;
  logic          key_any;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;

  logic [1:0]    fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;

  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic [1:0]    cmd_q;
  logic [1:0]    cmd_d;
  logic [GW-1:0] gap_cnt_q;
  logic [GW-1:0] gap_cnt_d;

  logic          i2c_req_q;
  logic          i2c_req_d;
  logic          i2c_rw_q;
  logic          i2c_rw_d;
  logic [7:0]    i2c_addr_q;
  logic [7:0]    i2c_addr_d;
  logic [7:0]    i2c_wr_data_q;
  logic [7:0]    i2c_wr_data_d;
  logic [7:0]    cur_addr_q;
  logic [7:0]    cur_addr_d;
  logic [7:0]    cur_data_q;
  logic [7:0]    cur_data_d;
  logic          rd_valid_q;
  logic          rd_valid_d;
  logic [7:0]    rd_data_q;
  logic [7:0]    rd_data_d;
  logic          err_flag_q;
  logic          err_flag_d;
  logic [7:0]    drop_cnt_q;
  logic [7:0]    drop_cnt_d;

  // Downward scan so the lowest set bit is the last (winning) assignment.
  always_comb begin
    key_cmd = 2'd0;
    key_cnt = 3'd0;
    for (int i = 3; i >= 0; i--) begin
      if (key_pulse_i[i]) key_cmd = 2'(i);
    end
    for (int i = 0; i < 4; i++) begin
      key_cnt = key_cnt + 3'(key_pulse_i[i]);
    end
  end

  assign key_any = |key_pulse_i;
  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = (state_q == S_IDLE) && !empty && !i2c_busy_i;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push    = key_any && (!full || pop);

  always_comb begin
    drops = 4'd0;
    if (key_any) drops = 4'(key_cnt) - 4'd1 + 4'(!push);
  end

  assign drop_sum   = {1'b0, drop_cnt_q} + 9'(drops);
  assign drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (!push && pop) count_d = count_q - 1'b1;
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge sclk_i) begin
    if (push) fifo_q[wr_ptr_q] <= key_cmd;
  end

  always_ff @(posedge sclk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    gap_cnt_d     = gap_cnt_q;
    i2c_req_d     = i2c_req_q;
    i2c_rw_d      = i2c_rw_q;
    i2c_addr_d    = i2c_addr_q;
    i2c_wr_data_d = i2c_wr_data_q;
    cur_addr_d    = cur_addr_q;
    cur_data_d    = cur_data_q;
    rd_valid_d    = 1'b0;
    rd_data_d     = rd_data_q;
    err_flag_d    = err_flag_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          cmd_d   = fifo_q[rd_ptr_q];
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        case (cmd_q)
          CMD_ADDR_INC: begin
            cur_addr_d = cur_addr_q + 8'd1;
            state_d    = S_IDLE;
          end
          CMD_DATA_INC: begin
            cur_data_d = cur_data_q + 8'd1;
            state_d    = S_IDLE;
          end
          default: begin
            // Snapshot here so later queued edits cannot disturb this transfer.
            i2c_addr_d    = cur_addr_q;
            i2c_wr_data_d = cur_data_q;
            i2c_rw_d      = (cmd_q == CMD_READ);
            i2c_req_d     = 1'b1;
            state_d       = S_REQ;
          end
        endcase
      end

      S_REQ: begin
        if (i2c_busy_i) begin
          i2c_req_d = 1'b0;
          state_d   = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (i2c_done_i) begin
          err_flag_d = err_flag_q | i2c_err_i;
          if (i2c_rw_q) begin
            if (!i2c_err_i) begin
              rd_data_d  = i2c_rd_data_i;
              rd_valid_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GW'(WR_GAP_CYCLES - 1)) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      cmd_q         <= CMD_WRITE;
      gap_cnt_q     <= '0;
      i2c_req_q     <= 1'b0;
      i2c_rw_q      <= 1'b0;
      i2c_addr_q    <= 8'd0;
      i2c_wr_data_q <= 8'd0;
      cur_addr_q    <= 8'd0;
      cur_data_q    <= 8'd0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= 8'd0;
      err_flag_q    <= 1'b0;
      drop_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      gap_cnt_q     <= gap_cnt_d;
      i2c_req_q     <= i2c_req_d;
      i2c_rw_q      <= i2c_rw_d;
      i2c_addr_q    <= i2c_addr_d;
      i2c_wr_data_q <= i2c_wr_data_d;
      cur_addr_q    <= cur_addr_d;
      cur_data_q    <= cur_data_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      err_flag_q    <= err_flag_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign i2c_req_o     = i2c_req_q;
  assign i2c_rw_o      = i2c_rw_q;
  assign i2c_addr_o    = i2c_addr_q;
  assign i2c_wr_data_o = i2c_wr_data_q;
  assign cur_addr_o    = cur_addr_q;
  assign cur_data_o    = cur_data_q;
  assign rd_valid_o    = rd_valid_q;
  assign rd_data_o     = rd_data_q;
  assign err_flag_o    = err_flag_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_key_eeprom_cmd_sched.sv
// Bench for key_eeprom_cmd_sched: directed scenarios plus randomized keys with an
// I2C responder, checked against a queue-based command model.
module tb_key_eeprom_cmd_sched;

  localparam int DEPTH = 4;
  localparam int GAP   = 16;

  logic       sclk = 1'b0;
  logic       rst;
  logic [3:0] key_pulse;
  logic       i2c_busy, i2c_done, i2c_err;
  logic [7:0] i2c_rd_data;
  logic       i2c_req, i2c_rw, rd_valid, err_flag;
  logic [7:0] i2c_addr, i2c_wr_data, cur_addr, cur_data, rd_data, drop_cnt;

  key_eeprom_cmd_sched #(.FIFO_DEPTH(DEPTH), .WR_GAP_CYCLES(GAP)) dut (
    .sclk_i(sclk), .rst_i(rst), .key_pulse_i(key_pulse),
    .i2c_busy_i(i2c_busy), .i2c_done_i(i2c_done), .i2c_err_i(i2c_err),
    .i2c_rd_data_i(i2c_rd_data),
    .i2c_req_o(i2c_req), .i2c_rw_o(i2c_rw), .i2c_addr_o(i2c_addr),
    .i2c_wr_data_o(i2c_wr_data), .cur_addr_o(cur_addr), .cur_data_o(cur_data),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .err_flag_o(err_flag),
    .drop_cnt_o(drop_cnt)
  );

  always #5 sclk = ~sclk;

  int cyc = 0;
  int req_hi = 0;
  always @(posedge sclk) cyc <= cyc + 1;
  always @(negedge sclk) if (i2c_req) req_hi <= req_hi + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: command queue in arrival order (0 WR, 1 RD, 2 AINC, 3 DINC)
  int         mq[$];
  logic [7:0] m_addr, m_data, m_rd;
  logic       m_err;
  int         m_drop;
  bit         last_wr;
  int         wr_done_cyc;

  function automatic void model_reset();
    mq.delete();
    m_addr = 0; m_data = 0; m_rd = 0; m_err = 0; m_drop = 0;
    last_wr = 0; wr_done_cyc = 0;
  endfunction

  function automatic void model_push(input logic [3:0] k, input bit full);
    int pc, w, nd;
    pc = 0; w = -1;
    for (int b = 0; b < 4; b++) if (k[b]) begin pc++; if (w < 0) w = b; end
    if (pc == 0) return;
    nd = pc - 1 + (full ? 1 : 0);
    if (!full) mq.push_back(w);
    m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
  endfunction

  // Retire local edits up to the next I2C command; -1 if nothing is pending.
  function automatic int model_take();
    int c;
    while (mq.size() > 0) begin
      c = mq.pop_front();
      if (c == 2) m_addr = m_addr + 8'd1;
      else if (c == 3) m_data = m_data + 8'd1;
      else return c;
    end
    return -1;
  endfunction

  task automatic press(input logic [3:0] k, input bit full);
    @(posedge sclk); #1 key_pulse = k; model_push(k, full);
    @(posedge sclk); #1 key_pulse = 4'd0;
  endtask

  task automatic wait_req(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge sclk);
      if (i2c_req) begin ok = 1; break; end
    end
    if (!ok) chk("req_timeout", 0, 1);
  endtask

  // Act as the I2C controller for one request; entered at a negedge with i2c_req high.
  task automatic serve(input bit err, input logic [7:0] data, input int d_busy, input int d_len);
    int c;
    bit rd;
    c = model_take();
    chk("req_expected", c >= 0, 1);
    rd = (c == 1);
    chk("req_rw", i2c_rw, rd);
    chk("req_addr", i2c_addr, m_addr);
    chk("req_wdata", i2c_wr_data, m_data);
    if (last_wr) chk("wr_gap_min", (cyc - wr_done_cyc) >= GAP + 2, 1);
    repeat (d_busy) begin @(negedge sclk); chk("req_hold", i2c_req, 1); end
    @(posedge sclk); #1 i2c_busy = 1;
    @(posedge sclk); @(negedge sclk); chk("req_drop", i2c_req, 0);
    repeat (d_len) @(posedge sclk);
    #1 i2c_busy = 0; i2c_done = 1; i2c_err = err; i2c_rd_data = data;
    @(posedge sclk); #1 i2c_done = 0; i2c_err = 0;
    @(negedge sclk);
    m_err = m_err | err;
    if (rd && !err) m_rd = data;
    chk("rd_valid", rd_valid, rd && !err);
    chk("rd_data", rd_data, m_rd);
    chk("err_flag", err_flag, m_err);
    last_wr = !rd;
    if (!rd) wr_done_cyc = cyc;
  endtask

  task automatic settle(input int n);
    int c;
    repeat (n) @(posedge sclk);
    @(negedge sclk);
    c = model_take();
    chk("lost_req", c, 32'hFFFF_FFFF);
    mq.delete();
    chk("idle_req", i2c_req, 0);
    chk("cur_addr", cur_addr, m_addr);
    chk("cur_data", cur_data, m_data);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("err_sticky", err_flag, m_err);
    chk("rd_data_hold", rd_data, m_rd);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req"}, i2c_req, 0);       chk({tag, "_rw"}, i2c_rw, 0);
    chk({tag, "_addr"}, i2c_addr, 0);     chk({tag, "_wdata"}, i2c_wr_data, 0);
    chk({tag, "_cur_addr"}, cur_addr, 0); chk({tag, "_cur_data"}, cur_data, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0); chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_err"}, err_flag, 0);      chk({tag, "_drop"}, drop_cnt, 0);
  endtask

  function automatic logic [3:0] rand_key();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 2) return 4'b0100;
    if (r <= 5) return 4'b1000;
    if (r == 6) return 4'b0001;
    if (r == 7) return 4'b0010;
    return 4'($urandom_range(1, 15));
  endfunction

  bit ok;
  bit stop;
  int r0;
  logic [3:0] ovf_pat [6];

  initial begin
    rst = 1; key_pulse = 0; i2c_busy = 0; i2c_done = 0; i2c_err = 0; i2c_rd_data = 0;
    model_reset();
    repeat (2) @(posedge sclk);
    @(negedge sclk); check_zero("rst");
    @(posedge sclk); #1 rst = 0;

    // Stray done outside WAIT_DONE
    @(posedge sclk); #1 i2c_done = 1; i2c_err = 1; i2c_rd_data = 8'hFF;
    @(posedge sclk); #1 i2c_done = 0; i2c_err = 0;
    @(negedge sclk); chk("stray_err", err_flag, 0); chk("stray_rdv", rd_valid, 0);

    // Local edits with latency check on the first one
    r0 = req_hi;
    press(4'b0100, 0);
    @(negedge sclk); @(negedge sclk); chk("lat_pre", cur_addr, 0);
    @(negedge sclk); chk("lat_post", cur_addr, 1);
    for (int i = 0; i < 5; i++) begin
      repeat (8) @(posedge sclk);
      press(i < 3 ? 4'b0100 : 4'b1000, 0);
    end
    settle(20);
    chk("local_addr4", cur_addr, 4); chk("local_data2", cur_data, 2);
    chk("local_no_req", req_hi - r0, 0);

    // Write 0x3C to 0x05, then read it back after the write gap
    press(4'b0100, 0);
    for (int i = 0; i < 58; i++) press(4'b1000, 0);
    settle(20);
    press(4'b0001, 0);
    wait_req(10, ok);
    if (ok) serve(0, 8'h00, 0, 100);
    press(4'b0010, 0);
    wait_req(GAP + 10, ok);
    if (ok) begin
      chk("gap_exact", cyc - wr_done_cyc, GAP + 2);
      serve(0, 8'h3C, 1, 3);
    end
    chk("readback", rd_data, 8'h3C);

    // NACK on read
    press(4'b0010, 0);
    wait_req(10, ok);
    if (ok) serve(1, 8'hA5, 0, 2);
    chk("nack_rd_data", rd_data, 8'h3C);

    // Simultaneous keys, overflow while stalled, push into full FIFO at pop
    press(4'b1011, 0);
    chk("drop_multi", drop_cnt, 2);
    wait_req(10, ok);
    if (ok) begin
      chk("ovf_wr_cmd", model_take(), 0);
      @(posedge sclk); #1 i2c_busy = 1;
      @(posedge sclk); #1;
      ovf_pat = '{4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
      for (int i = 0; i < 6; i++) press(ovf_pat[i], i >= DEPTH);
      chk("drop_full", drop_cnt, 4);
      @(posedge sclk); #1 i2c_busy = 0; i2c_done = 1;
      @(posedge sclk); #1 i2c_done = 0; wr_done_cyc = cyc; last_wr = 1;
      repeat (GAP) @(posedge sclk);
      #1 key_pulse = 4'b0100; model_push(4'b0100, 0);
      @(posedge sclk); #1 key_pulse = 0;
      chk("drop_pushpop", drop_cnt, 4);
      wait_req(GAP + 20, ok);
      if (ok) serve(0, 8'h5A, 2, 2);
    end
    settle(40);

    // Reset mid-GAP with three events queued
    press(4'b0001, 0);
    wait_req(10, ok);
    if (ok) serve(0, 8'h00, 0, 2);
    press(4'b0100, 0); press(4'b1000, 0); press(4'b0100, 0);
    @(posedge sclk); #1 rst = 1;
    @(negedge sclk); check_zero("midgap");
    @(posedge sclk); #1 rst = 0; model_reset();
    r0 = req_hi;
    repeat (30) @(posedge sclk);
    @(negedge sclk);
    chk("no_req_after_rst", req_hi - r0, 0);
    check_zero("post_rst");

    // Address wrap
    for (int i = 0; i < 256; i++) press(4'b0100, 0);
    settle(20);
    chk("addr_wrap", cur_addr, 0);

    // Randomized traffic with a concurrent responder
    stop = 0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          if (mq.size() >= DEPTH) settle(200);
          press(rand_key(), 0);
          repeat ($urandom_range(0, 4)) @(posedge sclk);
        end
        settle(200);
        stop = 1;
      end
      begin
        while (!stop) begin
          @(negedge sclk);
          if (i2c_req && !stop)
            serve($urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 3), $urandom_range(1, 5));
        end
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/key_eeprom_cmd_sched.md
# key_eeprom_cmd_sched

Command scheduler between the four debounced key pulses and the AT24C02 I2C read/write controller. Queues single-cycle key events in a small FIFO and executes them strictly in order. Local edits of the working address and data byte are applied immediately. EEPROM reads and writes are handed to the I2C controller with a req/busy/done handshake, and the AT24C02 internal write-cycle gap is enforced after every write.

## Interface
- FIFO_DEPTH, 4, command FIFO depth; power of two, ≥2.
- WR_GAP_CYCLES, 250_000, idle cycles after each write done (5 ms at 50 MHz).
- sclk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-high reset.
- key_pulse  input  4  one-cycle pulses from key debouncers; bit0 = WRITE, bit1 = READ, bit2 = ADDR_INC, bit3 = DATA_INC.
- i2c_busy  input  1  I2C controller has accepted a request and is running.
- i2c_done  input  1  one-cycle pulse at the end of the transaction.
- i2c_err  input  1  NACK seen; valid only with i2c_done.
- i2c_rd_data  input  8  read byte; valid with i2c_done on a read.
- i2c_req  output  1  request to the I2C controller.
- i2c_rw  output  1  1 = read, 0 = write; stable while i2c_req is high.
- i2c_addr  output  8  word address; equals cur_addr latched at dispatch.
- i2c_wr_data  output  8  write byte; equals cur_data latched at dispatch.
- cur_addr  output  8  working word address.
- cur_data  output  8  working data byte.
- rd_valid  output  1  one-cycle pulse when rd_data updates.
- rd_data  output  8  last byte read from the EEPROM.
- err_flag  output  1  sticky NACK indicator; cleared only by rst.
- drop_cnt  output  8  saturating count of discarded key events.

## Operation
- **Enqueue.** One event per cycle at most. If several key_pulse bits are high in the same cycle, the lowest bit index wins. Every other set bit counts as a drop. An event that arrives while the FIFO is full is also a drop. drop_cnt increases by the number of drops in that cycle and saturates at 255.
- **FSM states:** IDLE, DECODE, REQ, WAIT_DONE, GAP.
  - IDLE: if the FIFO is not empty and i2c_busy = 0, pop the head into cmd_reg and go to DECODE.
  - DECODE, ADDR_INC: cur_addr ← cur_addr + 1 (255 wraps to 0), then go to IDLE.
  - DECODE, DATA_INC: cur_data ← cur_data + 1 (255 wraps to 0), then go to IDLE.
  - DECODE, READ or WRITE: latch i2c_addr, i2c_wr_data and i2c_rw, then go to REQ.
  - REQ: hold i2c_req = 1 until i2c_busy = 1 is sampled. Drop i2c_req on the next edge and go to WAIT_DONE.
  - WAIT_DONE: on i2c_done, set err_flag if i2c_err = 1.
    - Read with no error: rd_data ← i2c_rd_data and pulse rd_valid, then go to IDLE.
    - Read with error: rd_data is unchanged, no rd_valid pulse, go to IDLE.
    - Write: go to GAP, whether or not an error occurred.
  - GAP: count WR_GAP_CYCLES cycles, then go to IDLE. The FIFO keeps accepting events during GAP.
- **Concurrent push/pop.** A push and a pop in the same cycle are both performed. Occupancy is unchanged, and a full FIFO accepts that push.
- **Ordering.** Commands execute in arrival order. A DATA_INC queued after a WRITE does not change that WRITE's data, because i2c_wr_data is latched at DECODE.
- **Reset.**
  - All outputs return to 0, the FIFO is emptied, the FSM returns to IDLE and the GAP counter is cleared.
  - Reset during REQ or WAIT_DONE abandons the transaction. The I2C controller is reset by the same rst.

## Timing
- **Reset values:** i2c_req, i2c_rw, rd_valid and err_flag are 0. i2c_addr, i2c_wr_data, cur_addr, cur_data, rd_data and drop_cnt are 0.
- **Key pulse to FIFO.** A key pulse sampled at edge t is in the FIFO after edge t.
- **Latency from an empty FIFO,** with i2c_busy = 0:
  - The pop happens at t+1 and DECODE is executed at t+2.
  - For a local command, cur_addr/cur_data show the new value after t+2.
  - For an I2C command, i2c_req is first high after t+2.
- **Request hold.** i2c_req stays high for at least 1 cycle. i2c_addr, i2c_wr_data and i2c_rw do not change from DECODE until the next DECODE.
- **Read result.** rd_valid is high exactly one cycle, in the cycle after i2c_done is sampled; rd_data is updated in that same cycle.
- **Write gap.** From the write's i2c_done to the next pop is WR_GAP_CYCLES + 1 cycles.
- **i2c_done outside WAIT_DONE** is ignored.

## Test plan
- **Reset.** Assert rst mid-GAP with 3 events queued → all outputs 0 next cycle. No i2c_req after release until a new key event.
- **Local edits.** Four bit2 pulses, then two bit3 pulses, 10 cycles apart → cur_addr = 4, cur_data = 2, i2c_req never asserted.
- **Write then read.** cur_addr = 0x05, cur_data = 0x3C, then a bit0 pulse → i2c_req with i2c_rw = 0, addr 0x05, data 0x3C.
  - Model done after 100 cycles, then press bit1 → the read is not requested before WR_GAP_CYCLES + 1 cycles have passed.
  - Model returns 0x3C → rd_valid pulse, rd_data = 0x3C.
- **Simultaneous keys and overflow.** key_pulse = 4'b1011 in one cycle → WRITE queued, drop_cnt = 2. Then with the FSM stalled by i2c_busy = 1, send 6 single pulses with FIFO_DEPTH = 4 → drop_cnt = 4.
- **NACK.** Read completes with i2c_err = 1 → err_flag = 1 and stays 1, rd_data unchanged, no rd_valid.
- **Wrap.** 256 ADDR_INC pulses → cur_addr returns to 0x00. Pushing into a full FIFO in the same cycle as a pop → the event is accepted and drop_cnt is unchanged.
